rand_pkt_seq: RTL and testbench

RAND_PKT_SEQ -- requirements
Module: rand_pkt_seq

---
 rtl/rand_pkt_seq.sv | 168 ++++++++++++++++
 tb/tb_rand_pkt_seq.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rand_pkt_seq.sv
// rand_pkt_seq: random-length packet generator driving an AXI4-Stream master.
//
// Each packet draws one 16-bit word from an external PRNG to pick its length,
// then draws DATA_WIDTH/16 words per beat to fill the payload.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start, num_pkts   one-cycle run request and packets per run (sampled on accept)
//   prng_en           advance strobe to the generator; prng_data consumed when high
//   prng_data         current generator output word
//   m_axis_*          AXI4-Stream master (tdata, tkeep, tvalid, tready, tlast)
//   busy              high from start acceptance until the run finishes
//   done              one-cycle pulse at the end of a run
//   pkts_sent         packets fully transferred in the current/last run

module rand_pkt_seq #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned MAX_LEN_BYTES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [15:0]             num_pkts,
    output logic                    prng_en,
    input  logic [15:0]             prng_data,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             pkts_sent
);

    localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
    localparam int unsigned WORDS      = DATA_WIDTH / 16;
    localparam int unsigned WCW        = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS - 1);
    localparam logic [15:0]    LEN_MASK  = 16'(MAX_LEN_BYTES - 1);
    localparam logic [16:0]    BEAT_LEN  = 17'(BEAT_BYTES);

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StFill,
        StSend,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [15:0]             count_q, count_d;
    logic [15:0]             sent_q, sent_d;
    // Bytes still to send in the current packet, including the beat being built.
    logic [16:0]             rem_q, rem_d;
    logic [WCW-1:0]          wcnt_q, wcnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;

    logic                    is_last;
    logic [BEAT_BYTES-1:0]   keep;
    logic                    in_send;

    assign is_last = (rem_q <= BEAT_LEN);
    assign in_send = (state_q == StSend);

    // Byte enables: all ones except on the final beat, where only the low
    // `rem_q` bytes are valid.
    always_comb begin
        keep = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            keep[i] = !is_last || (17'(i) < rem_q);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sent_d  = sent_q;
        rem_d   = rem_q;
        wcnt_d  = wcnt_q;
        data_d  = data_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    count_d = num_pkts;
                    sent_d  = '0;
                    state_d = (num_pkts == 16'd0) ? StDone : StLen;
                end
            end
            StLen: begin
                rem_d   = {1'b0, prng_data & LEN_MASK} + 17'd1;
                wcnt_d  = '0;
                state_d = StFill;
            end
            StFill: begin
                for (int k = 0; k < WORDS; k++) begin
                    if (wcnt_q == WCW'(k)) begin
                        data_d[16*k +: 16] = prng_data;
                    end
                end
                if (wcnt_q == LAST_WORD) begin
                    wcnt_d  = '0;
                    state_d = StSend;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            StSend: begin
                if (m_axis_tready) begin
                    if (is_last) begin
                        sent_d  = sent_q + 16'd1;
                        state_d = (sent_q + 16'd1 == count_q) ? StDone : StLen;
                    end else begin
                        rem_d   = rem_q - BEAT_LEN;
                        state_d = StFill;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            sent_q  <= '0;
            rem_q   <= '0;
            wcnt_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sent_q  <= sent_d;
            rem_q   <= rem_d;
            wcnt_q  <= wcnt_d;
            data_q  <= data_d;
        end
    end

    // Outputs. Stream fields are forced to zero outside SEND so that idle and
    // reset present a clean bus; inside SEND they derive only from registers
    // and therefore hold steady under backpressure.
    always_comb begin
        m_axis_tvalid = in_send;
        m_axis_tlast  = in_send && is_last;
        m_axis_tkeep  = in_send ? keep : '0;
        m_axis_tdata  = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            if (in_send && keep[i]) begin
                m_axis_tdata[8*i +: 8] = data_q[8*i +: 8];
            end
        end
        prng_en   = (state_q == StLen) || (state_q == StFill);
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        pkts_sent = sent_q;
    end

endmodule

// File: tb/tb_rand_pkt_seq.sv
// Bench for rand_pkt_seq (DATA_WIDTH=64, MAX_LEN_BYTES=1024). A table-driven
// PRNG stand-in feeds words in consumption order; expected beats are derived
// from the table and queued, then popped as the DUT hands beats off.

module tb_rand_pkt_seq;

    localparam int unsigned DW = 64;
    localparam int unsigned KW = DW / 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   num_pkts;
    logic          prng_en;
    logic [15:0]   prng_data;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic          busy;
    logic          done;
    logic [15:0]   pkts_sent;

    rand_pkt_seq #(
        .DATA_WIDTH   (DW),
        .MAX_LEN_BYTES(1024)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_pkts     (num_pkts),
        .prng_en      (prng_en),
        .prng_data    (prng_data),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .busy         (busy),
        .done         (done),
        .pkts_sent    (pkts_sent)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // PRNG stand-in: word index advances on every cycle the DUT strobes prng_en.
    logic [15:0] tab [4096];
    int          prng_ptr = 0;
    int          base     = 0;

    assign prng_data = tab[12'(prng_ptr - base)];

    always @(posedge clk) begin
        if (prng_en) prng_ptr <= prng_ptr + 1;
    end

    // Scoreboard and monitor state.
    beat_t         exp_q[$];
    int            exp_beats;
    int            acc_cnt, last_cnt, done_cnt;
    int            tready_mode = 0;
    int            stall_left  = 0;
    logic [DW-1:0] last_data;
    bit            hold_pending = 0;
    logic [DW-1:0] hold_data;
    logic [KW-1:0] hold_keep;
    logic          hold_last;

    function automatic void fill_rand();
        for (int i = 0; i < 4096; i++) tab[i] = 16'($urandom);
    endfunction

    // Walk the table in consumption order: one length word per packet, then
    // four payload words per beat.
    function automatic void build(input int n, output int words);
        int    p = 0;
        int    len, rem;
        beat_t b;
        for (int pk = 0; pk < n; pk++) begin
            len = int'(tab[p] & 16'h03FF) + 1;
            p++;
            rem = len;
            while (rem > 0) begin
                b.data = '0;
                for (int k = 0; k < 4; k++) begin
                    b.data[16*k +: 16] = tab[p];
                    p++;
                end
                if (rem <= 8) begin
                    b.keep = 8'hFF >> (8 - rem);
                    b.last = 1'b1;
                    for (int i = 0; i < 8; i++) if (!b.keep[i]) b.data[8*i +: 8] = 8'h00;
                    rem = 0;
                end else begin
                    b.keep = 8'hFF;
                    b.last = 1'b0;
                    rem -= 8;
                end
                exp_q.push_back(b);
            end
        end
        words = p;
    endfunction

    // Monitor: at the falling edge choose tready for the coming rising edge,
    // then any beat with tvalid && tready is the one that edge will accept.
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 0;
        end else begin
            if (done) done_cnt++;
            if (hold_pending) begin
                check_eq("hold_tvalid", 64'(m_axis_tvalid), 64'd1);
                check_eq("hold_tdata", m_axis_tdata, hold_data);
                check_eq("hold_tkeep", 64'(m_axis_tkeep), 64'(hold_keep));
                check_eq("hold_tlast", 64'(m_axis_tlast), 64'(hold_last));
            end
            case (tready_mode)
                1: m_axis_tready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (m_axis_tvalid && stall_left > 0) begin
                        m_axis_tready = 1'b0;
                        stall_left--;
                    end else begin
                        m_axis_tready = 1'b1;
                    end
                end
                default: m_axis_tready = 1'b1;
            endcase
            if (m_axis_tvalid && m_axis_tready) begin
                acc_cnt++;
                if (m_axis_tlast) last_cnt++;
                last_data = m_axis_tdata;
                if (exp_q.size() == 0) begin
                    check_eq("beat_count", 64'(acc_cnt), 64'(exp_beats));
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check_eq("tdata", m_axis_tdata, e.data);
                    check_eq("tkeep", 64'(m_axis_tkeep), 64'(e.keep));
                    check_eq("tlast", 64'(m_axis_tlast), 64'(e.last));
                end
            end
            hold_pending = m_axis_tvalid && !m_axis_tready;
            if (hold_pending) begin
                hold_data = m_axis_tdata;
                hold_keep = m_axis_tkeep;
                hold_last = m_axis_tlast;
                check_eq("stall_prng_en", 64'(prng_en), 64'd0);
            end
        end
    end

    task automatic prep(input int n, output int words);
        base = prng_ptr;
        exp_q.delete();
        build(n, words);
        exp_beats = exp_q.size();
        acc_cnt   = 0;
        last_cnt  = 0;
        done_cnt  = 0;
    endtask

    task automatic pulse_start(input logic [15:0] n);
        @(posedge clk); #1;
        start    = 1'b1;
        num_pkts = n;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic run_pkts(input int n, input int mode, input bit poke);
        int words;
        bit got = 0;
        prep(n, words);
        tready_mode = mode;
        pulse_start(16'(n));
        check_eq("busy_after_start", 64'(busy), 64'd1);
        if (poke) begin
            repeat (2) @(posedge clk);
            #1;
            start    = 1'b1;
            num_pkts = 16'd5;
            @(posedge clk); #1;
            start    = 1'b0;
        end
        for (int c = 0; c < 40000; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        check_eq("done_seen", 64'(got), 64'd1);
        @(posedge clk); #1;
        check_eq("busy_after_done", 64'(busy), 64'd0);
        check_eq("done_one_cycle", 64'(done), 64'd0);
        check_eq("pkts_sent", 64'(pkts_sent), 64'(n));
        check_eq("done_pulses", 64'(done_cnt), 64'd1);
        check_eq("beats_left", 64'(exp_q.size()), 64'd0);
        check_eq("beats_sent", 64'(acc_cnt), 64'(exp_beats));
        check_eq("tlast_count", 64'(last_cnt), 64'(n));
        check_eq("prng_words", 64'(prng_ptr - base), 64'(words));
    endtask

    initial begin
        int  words;
        bit  found;
        rst      = 1'b1;
        start    = 1'b0;
        num_pkts = '0;
        fill_rand();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_eq("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check_eq("rst_prng_en", 64'(prng_en), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_tdata", m_axis_tdata, 64'd0);
        check_eq("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
        check_eq("rst_pkts_sent", 64'(pkts_sent), 64'd0);
        rst = 1'b0;

        // Empty run: busy for one cycle with the done pulse, nothing else.
        run_pkts(0, 0, 0);

        // Four-byte packet.
        tab[0] = 16'h0003; tab[1] = 16'h1111; tab[2] = 16'h2222;
        tab[3] = 16'h3333; tab[4] = 16'h4444;
        run_pkts(1, 0, 0);
        check_eq("short_pkt_tdata", last_data, 64'h0000_0000_2222_1111);

        // Maximum length: 128 full beats.
        fill_rand();
        tab[0] = 16'h03FF;
        run_pkts(1, 0, 0);
        check_eq("max_len_beats", 64'(acc_cnt), 64'd128);

        // Single-byte packet.
        fill_rand();
        tab[0] = 16'h0400;
        run_pkts(1, 0, 0);
        check_eq("one_byte_tdata", last_data, 64'(tab[1] & 16'h00FF));

        // Five-cycle stall on the first beat of a two-beat packet.
        fill_rand();
        tab[0]     = 16'h000F;
        stall_left = 5;
        run_pkts(1, 2, 0);

        // Random lengths with random backpressure.
        fill_rand();
        run_pkts(3, 1, 0);

        // Reset on beat 2 of a four-beat packet.
        fill_rand();
        tab[0] = 16'h001F;
        prep(2, words);
        tready_mode = 0;
        pulse_start(16'd2);
        found = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (acc_cnt == 1 && m_axis_tvalid) begin
                found = 1;
                break;
            end
        end
        check_eq("reached_beat2", 64'(found), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_pkts_sent", 64'(pkts_sent), 64'd0);
        rst = 1'b0;
        fill_rand();
        run_pkts(2, 1, 0);

        // Start reissued while busy must not restart or extend the run.
        fill_rand();
        run_pkts(2, 1, 1);
        repeat (20) @(posedge clk);
        #1;
        check_eq("ignored_start_done", 64'(done_cnt), 64'd1);
        check_eq("ignored_start_busy", 64'(busy), 64'd0);
        check_eq("ignored_start_sent", 64'(pkts_sent), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
